// File: rtl/serial_arith_pkg.sv
// Shared types for the digit-serial arithmetic blocks: op mode, result flags, count sizing.
package serial_arith_pkg;

   localparam int unsigned DEF_MAX_DIGITS = 16;
   localparam int unsigned DEF_CNT_W      = $clog2(DEF_MAX_DIGITS + 1);

   typedef enum logic {OP_ADD, OP_SUB} op_e;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic len_err;
   } flags_t;

   function automatic int unsigned cnt_width(input int unsigned max_digits);
      return $clog2(max_digits + 1);
   endfunction

endpackage

// File: rtl/digit_addsub.sv
// One DIGIT_W-wide add/subtract slice; exposes the carry into the MSB for overflow detection.
module digit_addsub #(
   parameter int unsigned DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   input  logic               inv_b,
   output logic [DIGIT_W-1:0] s,
   output logic               cout,
   output logic               c_msb
);

   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W:0]   full;

   always_comb begin
      b_eff = inv_b ? ~b : b;
      full  = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
      s     = full[DIGIT_W-1:0];
      cout  = full[DIGIT_W];
      // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
      c_msb = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
   end

endmodule

// File: rtl/serial_addsub_digit_vld.sv
// Digit-serial adder/subtractor, LS digit first, one registered result digit per valid cycle.
module serial_addsub_digit_vld
   import serial_arith_pkg::*;
#(
   parameter int unsigned DIGIT_W    = 4,
   parameter int unsigned MAX_DIGITS = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              vld,
   input  logic [DIGIT_W-1:0]                a,
   input  logic [DIGIT_W-1:0]                b,
   input  logic                              sub,
   input  logic                              last,
   output logic                              sum_vld,
   output logic [DIGIT_W-1:0]                sum,
   output logic                              sum_last,
   output logic                              cout,
   output logic                              ovf,
   output logic                              len_err,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   n_digits
);

   localparam int unsigned CNT_W = cnt_width(MAX_DIGITS);

   logic               first_q, first_d;
   op_e                mode_q, mode_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sum_vld_q, sum_vld_d;
   logic [DIGIT_W-1:0] sum_q, sum_d;
   logic               sum_last_q, sum_last_d;
   flags_t             flags_q, flags_d;
   logic [CNT_W-1:0]   n_digits_q, n_digits_d;

   op_e                mode_eff;
   logic               cin;
   logic               word_end;
   logic [DIGIT_W-1:0] s;
   logic               c;
   logic               c_msb;

   digit_addsub #(
      .DIGIT_W (DIGIT_W)
   ) u_digit_addsub (
      .a     (a),
      .b     (b),
      .cin   (cin),
      .inv_b (mode_eff == OP_SUB),
      .s     (s),
      .cout  (c),
      .c_msb (c_msb)
   );

   always_comb begin
      mode_eff = first_q ? op_e'(sub) : mode_q;
      cin      = first_q ? sub : carry_q;
      word_end = vld & (last | (cnt_q == CNT_W'(MAX_DIGITS - 1)));

      first_d    = first_q;
      mode_d     = mode_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      sum_vld_d  = vld;
      sum_d      = sum_q;
      sum_last_d = sum_last_q;
      flags_d    = flags_q;
      n_digits_d = n_digits_q;

      if (vld) begin
         mode_d     = mode_eff;
         sum_d      = s;
         sum_last_d = word_end;
         if (word_end) begin
            first_d    = 1'b1;
            carry_d    = 1'b0;
            cnt_d      = '0;
            flags_d    = '{cout: c, ovf: c_msb ^ c, len_err: ~last};
            n_digits_d = cnt_q + CNT_W'(1);
         end else begin
            first_d = 1'b0;
            carry_d = c;
            cnt_d   = cnt_q + CNT_W'(1);
            flags_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q    <= 1'b1;
         mode_q     <= OP_ADD;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         sum_vld_q  <= 1'b0;
         sum_q      <= '0;
         sum_last_q <= 1'b0;
         flags_q    <= '0;
         n_digits_q <= '0;
      end else begin
         first_q    <= first_d;
         mode_q     <= mode_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         sum_vld_q  <= sum_vld_d;
         sum_q      <= sum_d;
         sum_last_q <= sum_last_d;
         flags_q    <= flags_d;
         n_digits_q <= n_digits_d;
      end
   end

   assign sum_vld  = sum_vld_q;
   assign sum      = sum_q;
   assign sum_last = sum_last_q;
   assign cout     = flags_q.cout;
   assign ovf      = flags_q.ovf;
   assign len_err  = flags_q.len_err;
   assign n_digits = n_digits_q;

endmodule
